// File: rtl/regfile_pkg.sv
// Shared widths, constants and write-request payload for the register file.
package regfile_pkg;

    localparam int unsigned RADDR_WIDTH = 5;
    localparam int unsigned RDATA_WIDTH = 32;
    localparam int unsigned NUM_REGS    = 32;

    localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;
    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;

    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // One write into the array, already qualified (en=0 means nothing commits)
    typedef struct packed {
        logic                   en;
        logic [RADDR_WIDTH-1:0] addr;
        logic [RDATA_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile.sv
// 31-entry register file: two bypassed read ports, one writeback write port,
// and a handshaked debug/loader port that loses to writeback on collisions.
module regfile
    import regfile_pkg::*;
#(
    parameter bit DBG_EN = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
    input  logic                   reg1_re_i,
    output logic [RDATA_WIDTH-1:0] reg1_rdata_o,
    input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
    input  logic                   reg2_re_i,
    output logic [RDATA_WIDTH-1:0] reg2_rdata_o,
    input  logic                   wb_we_i,
    input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [RDATA_WIDTH-1:0] wb_wdata_i,
    input  logic                   dbg_req_i,
    input  logic [RADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [RDATA_WIDTH-1:0] dbg_wdata_i,
    output logic                   dbg_ack_o,
    output logic [RDATA_WIDTH-1:0] dbg_rdata_o,
    output logic [31:0]            written_o
);

    // x0 has no storage; the array is indexed 1..31
    logic [RDATA_WIDTH-1:0] mem_q [1:NUM_REGS-1];
    logic [RDATA_WIDTH-1:0] mem_d [1:NUM_REGS-1];
    logic [31:0]            written_q, written_d;
    logic                   dbg_ack_q, dbg_ack_d;

    wr_req_t                wb_wr;
    wr_req_t                dbg_wr;
    logic                   dbg_accept;
    logic [RDATA_WIDTH-1:0] rd1_arr, rd2_arr, dbg_arr;

    // Qualify the two write sources; debug yields to a same-address writeback
    always_comb begin
        wb_wr.en   = (wb_we_i == WRITE_ENABLE) && (wb_waddr_i != ZERO_REG);
        wb_wr.addr = wb_waddr_i;
        wb_wr.data = wb_wdata_i;

        dbg_accept  = DBG_EN && dbg_req_i && !dbg_ack_q
                      && !(wb_wr.en && (wb_waddr_i == dbg_addr_i));
        dbg_wr.en   = dbg_accept && (dbg_addr_i != ZERO_REG);
        dbg_wr.addr = dbg_addr_i;
        dbg_wr.data = dbg_wdata_i;
    end

    // Next-state for the array, written mask and ack pulse
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        dbg_ack_d = dbg_accept;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wb_wr.en && (wb_wr.addr == RADDR_WIDTH'(i))) begin
                mem_d[i]     = wb_wr.data;
                written_d[i] = 1'b1;
            end else if (dbg_wr.en && (dbg_wr.addr == RADDR_WIDTH'(i))) begin
                mem_d[i]     = dbg_wr.data;
                written_d[i] = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                mem_q[i] <= ZERO;
            end
            written_q <= '0;
            dbg_ack_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            written_q <= written_d;
            dbg_ack_q <= dbg_ack_d;
        end
    end

    // Raw array lookups for the three read addresses (x0 falls through to ZERO)
    always_comb begin
        rd1_arr = ZERO;
        rd2_arr = ZERO;
        dbg_arr = ZERO;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (reg1_raddr_i == RADDR_WIDTH'(i)) rd1_arr = mem_q[i];
            if (reg2_raddr_i == RADDR_WIDTH'(i)) rd2_arr = mem_q[i];
            if (dbg_addr_i   == RADDR_WIDTH'(i)) dbg_arr = mem_q[i];
        end
    end

    // Read muxes with write-first bypass; bypass is held off while in reset
    always_comb begin
        reg1_rdata_o = ZERO;
        reg2_rdata_o = ZERO;
        if ((reg1_re_i == READ_ENABLE) && (reg1_raddr_i != ZERO_REG)) begin
            reg1_rdata_o = (rst_n_i && wb_wr.en && (wb_wr.addr == reg1_raddr_i))
                           ? wb_wr.data : rd1_arr;
        end
        if ((reg2_re_i == READ_ENABLE) && (reg2_raddr_i != ZERO_REG)) begin
            reg2_rdata_o = (rst_n_i && wb_wr.en && (wb_wr.addr == reg2_raddr_i))
                           ? wb_wr.data : rd2_arr;
        end
    end

    assign dbg_rdata_o = DBG_EN ? dbg_arr : ZERO;
    assign dbg_ack_o   = dbg_ack_q;
    assign written_o   = written_q;

endmodule
